// File: rtl/riscv_if_pkg.sv
// Shared types, constants and helpers for the RV32IC instruction-fetch stage.
package riscv_if_pkg;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned HW_W    = 16;
    localparam int unsigned WADDR_W = 30;

    localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0013;

    // FETCH: word-aligned, buffer empty; HALF: buffer holds halfword at pc;
    // SKIP: redirected to an odd halfword, low half of the first word is dropped.
    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HALF  = 2'd1,
        SKIP  = 2'd2
    } fetch_state_t;

    // RVC instructions are the ones whose two low bits are not 2'b11.
    function automatic logic is_compressed(input logic [HW_W-1:0] hw);
        return hw[1:0] != 2'b11;
    endfunction

endpackage

// File: rtl/if_realign.sv
// Combinational realignment of the 16/32-bit instruction stream through a one-halfword buffer.
module if_realign
    import riscv_if_pkg::*;
(
    input  fetch_state_t         state,
    input  logic [HW_W-1:0]      buf_data,
    input  logic [XLEN-1:0]      rdata,
    input  logic [XLEN-1:0]      pc,
    output logic [XLEN-1:0]      inst,
    output logic                 compressed,
    output logic [2:0]           pc_inc,
    output logic [HW_W-1:0]      buf_next,
    output logic                 need_word,
    output logic [WADDR_W-1:0]   word_addr,
    output fetch_state_t         state_next
);

    // Select the issued instruction, the pc step and the next buffer/state.
    always_comb begin
        inst       = NOP_INST;
        compressed = 1'b0;
        pc_inc     = 3'd0;
        buf_next   = buf_data;
        need_word  = 1'b0;
        word_addr  = pc[XLEN-1:2];
        state_next = state;
        case (state)
            FETCH: begin
                need_word = 1'b1;
                if (is_compressed(rdata[HW_W-1:0])) begin
                    inst       = {16'h0, rdata[HW_W-1:0]};
                    compressed = 1'b1;
                    pc_inc     = 3'd2;
                    buf_next   = rdata[XLEN-1:HW_W];
                    state_next = HALF;
                end else begin
                    inst       = rdata;
                    pc_inc     = 3'd4;
                    state_next = FETCH;
                end
            end
            HALF: begin
                if (is_compressed(buf_data)) begin
                    inst       = {16'h0, buf_data};
                    compressed = 1'b1;
                    pc_inc     = 3'd2;
                    state_next = FETCH;
                end else begin
                    // Upper half of the instruction lives in the next word (pc is odd-halfword).
                    need_word  = 1'b1;
                    word_addr  = pc[XLEN-1:2] + 30'd1;
                    inst       = {rdata[HW_W-1:0], buf_data};
                    pc_inc     = 3'd4;
                    buf_next   = rdata[XLEN-1:HW_W];
                    state_next = HALF;
                end
            end
            SKIP: begin
                need_word  = 1'b1;
                buf_next   = rdata[XLEN-1:HW_W];
                state_next = HALF;
            end
            default: begin
                state_next = FETCH;
            end
        endcase
    end

endmodule

// File: rtl/riscv_if.sv
// Instruction-fetch stage: owns the PC, drives the I-cache and produces the IF/ID register.
module riscv_if
    import riscv_if_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 stall,
    input  logic                 flush,
    input  logic                 redirect_valid,
    input  logic [XLEN-1:0]      redirect_pc,
    output logic                 icache_ren,
    output logic [WADDR_W-1:0]   icache_addr,
    input  logic [XLEN-1:0]      icache_rdata,
    input  logic                 icache_stall,
    output logic [XLEN-1:0]      inst_ppl,
    output logic [XLEN-1:0]      pc_ppl,
    output logic                 compressed_ppl,
    output logic [XLEN-1:0]      pred_dest_ppl
);

    logic [XLEN-1:0]    pc;
    fetch_state_t       state;
    logic [HW_W-1:0]    buf_data;

    logic [XLEN-1:0]    ra_inst;
    logic               ra_compressed;
    logic [2:0]         ra_pc_inc;
    logic [HW_W-1:0]    ra_buf_next;
    logic               ra_need_word;
    logic [WADDR_W-1:0] ra_word_addr;
    fetch_state_t       ra_state_next;

    logic [XLEN-1:0]    pc_plus2;
    logic [XLEN-1:0]    pc_plus4;

    if_realign u_realign (
        .state      (state),
        .buf_data   (buf_data),
        .rdata      (icache_rdata),
        .pc         (pc),
        .inst       (ra_inst),
        .compressed (ra_compressed),
        .pc_inc     (ra_pc_inc),
        .buf_next   (ra_buf_next),
        .need_word  (ra_need_word),
        .word_addr  (ra_word_addr),
        .state_next (ra_state_next)
    );

    assign icache_ren  = ra_need_word;
    assign icache_addr = ra_word_addr;
    assign pc_plus2    = pc + 32'd2;
    assign pc_plus4    = pc + 32'd4;

    // Fetch state and IF/ID register update in priority order: redirect, stall, flush/miss, advance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc             <= RESET_PC;
            state          <= FETCH;
            buf_data       <= '0;
            inst_ppl       <= NOP_INST;
            pc_ppl         <= '0;
            compressed_ppl <= 1'b0;
            pred_dest_ppl  <= '0;
        end else if (redirect_valid) begin
            pc             <= {redirect_pc[XLEN-1:1], 1'b0};
            state          <= redirect_pc[1] ? SKIP : FETCH;
            buf_data       <= '0;
            inst_ppl       <= NOP_INST;
            pc_ppl         <= pc;
            compressed_ppl <= 1'b0;
            pred_dest_ppl  <= pc_plus4;
        end else if (stall) begin
            pc             <= pc;
        end else if (flush || (ra_need_word && icache_stall)) begin
            inst_ppl       <= NOP_INST;
            pc_ppl         <= pc;
            compressed_ppl <= 1'b0;
            pred_dest_ppl  <= pc_plus4;
        end else begin
            inst_ppl       <= ra_inst;
            pc_ppl         <= pc;
            compressed_ppl <= ra_compressed;
            pred_dest_ppl  <= ra_compressed ? pc_plus2 : pc_plus4;
            pc             <= pc + 32'(ra_pc_inc);
            state          <= ra_state_next;
            buf_data       <= ra_buf_next;
        end
    end

endmodule

// File: tb/tb_riscv_if.sv
// Directed scoreboard bench for the riscv_if fetch stage.
module tb_riscv_if;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        flush;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        icache_ren;
    logic [29:0] icache_addr;
    logic [31:0] icache_rdata;
    logic        icache_stall;
    logic [31:0] inst_ppl;
    logic [31:0] pc_ppl;
    logic        compressed_ppl;
    logic [31:0] pred_dest_ppl;

    logic [31:0] mem [256];

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
        logic        comp;
        logic [31:0] pred;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    riscv_if #(.RESET_PC(32'h0000_0000)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .stall          (stall),
        .flush          (flush),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .icache_ren     (icache_ren),
        .icache_addr    (icache_addr),
        .icache_rdata   (icache_rdata),
        .icache_stall   (icache_stall),
        .inst_ppl       (inst_ppl),
        .pc_ppl         (pc_ppl),
        .compressed_ppl (compressed_ppl),
        .pred_dest_ppl  (pred_dest_ppl)
    );

    assign icache_rdata = mem[icache_addr[7:0]];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [31:0] inst, input logic [31:0] pc,
                        input logic comp, input logic [31:0] pred);
        exp_t e;
        e.inst = inst;
        e.pc   = pc;
        e.comp = comp;
        e.pred = pred;
        exp_q.push_back(e);
    endtask

    task automatic push_nop(input logic [31:0] pc);
        push(NOP, pc, 1'b0, pc + 32'd4);
    endtask

    task automatic req(input logic ren, input logic [29:0] addr);
        check("icache_ren", 32'(icache_ren), 32'(ren));
        if (ren) check("icache_addr", 32'(icache_addr), 32'(addr));
    endtask

    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL scoreboard_empty observed=%h expected=none", pc_ppl);
        end else begin
            e = exp_q.pop_front();
            check("inst_ppl", inst_ppl, e.inst);
            check("pc_ppl", pc_ppl, e.pc);
            check("compressed_ppl", 32'(compressed_ppl), 32'(e.comp));
            check("pred_dest_ppl", pred_dest_ppl, e.pred);
        end
    endtask

    task automatic check_reset_outputs();
        check("rst_inst", inst_ppl, NOP);
        check("rst_pc", pc_ppl, 32'h0);
        check("rst_comp", 32'(compressed_ppl), 32'h0);
        check("rst_pred", pred_dest_ppl, 32'h0);
        req(1'b1, 30'h0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        mem[0]     = 32'h0050_0093;
        mem[1]     = 32'h00A0_0113;
        mem[2]     = 32'h0030_0193;
        mem[3]     = 32'h0040_0213;
        mem[8]     = 32'h0001_4505;
        mem[12]    = 32'h0093_4505;
        mem[13]    = 32'hABCD_0050;
        mem[8'h40] = 32'h0093_1234;
        mem[8'h41] = 32'h5555_0050;
        mem[8'hFF] = 32'h0001_4505;

        rst_n          = 1'b0;
        stall          = 1'b0;
        flush          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        icache_stall   = 1'b0;

        #12;
        check_reset_outputs();
        @(negedge clk);
        rst_n = 1'b1;

        // Two 32-bit instructions from reset.
        req(1'b1, 30'd0); push(32'h0050_0093, 32'h0, 1'b0, 32'h4); tick();
        req(1'b1, 30'd1); push(32'h00A0_0113, 32'h4, 1'b0, 32'h8); tick();

        // Three-cycle cache miss at pc 8.
        icache_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            req(1'b1, 30'd2); push_nop(32'h8); tick();
        end
        icache_stall = 1'b0;
        req(1'b1, 30'd2); push(32'h0030_0193, 32'h8, 1'b0, 32'hC); tick();

        // Hazard stall freezes IF/ID, then flush squashes and the pc is re-fetched.
        stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            req(1'b1, 30'd3); push(32'h0030_0193, 32'h8, 1'b0, 32'hC); tick();
        end
        stall = 1'b0;
        flush = 1'b1;
        push_nop(32'hC); tick();
        flush = 1'b0;
        req(1'b1, 30'd3); push(32'h0040_0213, 32'hC, 1'b0, 32'h10); tick();

        // Redirect (bit 0 set, ignored) to a word of two compressed halfwords.
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0021;
        push_nop(32'h10); tick();
        redirect_valid = 1'b0;
        req(1'b1, 30'd8); push(32'h0000_4505, 32'h20, 1'b1, 32'h22); tick();
        req(1'b0, 30'd0); push(32'h0000_0001, 32'h22, 1'b1, 32'h24); tick();

        // Compressed, then a 32-bit instruction spanning two words, then a buffered compressed.
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0030;
        push_nop(32'h24); tick();
        redirect_valid = 1'b0;
        req(1'b1, 30'd12); push(32'h0000_4505, 32'h30, 1'b1, 32'h32); tick();
        req(1'b1, 30'd13); push(32'h0050_0093, 32'h32, 1'b0, 32'h36); tick();
        req(1'b0, 30'd0);  push(32'h0000_ABCD, 32'h36, 1'b1, 32'h38); tick();

        // Redirect to an odd halfword wins over stall and cache miss; SKIP bubble follows.
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0102;
        stall = 1'b1; icache_stall = 1'b1;
        push_nop(32'h38); tick();
        redirect_valid = 1'b0; stall = 1'b0; icache_stall = 1'b0;
        req(1'b1, 30'h40); push_nop(32'h102); tick();
        req(1'b1, 30'h41); push(32'h0050_0093, 32'h102, 1'b0, 32'h106); tick();

        // Buffered compressed issues despite a cache miss.
        icache_stall = 1'b1;
        req(1'b0, 30'd0); push(32'h0000_5555, 32'h106, 1'b1, 32'h108); tick();
        icache_stall = 1'b0;

        // PC wraps from the top of the address space to zero.
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        push_nop(32'h108); tick();
        redirect_valid = 1'b0;
        req(1'b1, 30'h3FFF_FFFF); push(32'h0000_4505, 32'hFFFF_FFFC, 1'b1, 32'hFFFF_FFFE); tick();
        req(1'b0, 30'd0);         push(32'h0000_0001, 32'hFFFF_FFFE, 1'b1, 32'h0); tick();
        req(1'b1, 30'd0);         push(32'h0050_0093, 32'h0, 1'b0, 32'h4); tick();

        // Reset asserted in the middle of a miss clears everything without a clock edge.
        icache_stall = 1'b1;
        req(1'b1, 30'd1); push_nop(32'h4); tick();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset_outputs();

        check("scoreboard_drained", 32'(exp_q.size()), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
